ftoi_pipe: RTL and testbench
============================

// Module: ftoi_pipe
// PURPOSE
//  Pipelined single-precision float -> signed 32-bit integer converter; inverse of the itof unit.
//  Sits in the FPU beside itof, feeding the CPU's ftoi/cvt instruction path.
//  Fixed 2-cycle latency, one op per cycle, valid-tagged.
//  Rounds to nearest, ties to even. Out-of-range inputs and NaN saturate.
// PARAMETERS
//  SAT_ENABLE  1  1: overflow/NaN saturate by sign (NaN -> 32'h7FFFFFFF); 0: all overflow/NaN -> 32'h80000000
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  op         in   32  IEEE-754 binary32 operand
//  valid_in   in   1   op is sampled at this edge
//  result     out  32  two's-complement integer, registered
//  valid_out  out  1   result corresponds to op accepted 2 edges earlier
//  ovf        out  1   result saturated (|x| >= 2^31 except exactly -2^31, Inf, NaN)
// BEHAVIOUR
//  Reset:
//   - result=0, valid_out=0, ovf=0; both stage valid bits cleared.
//   - In-flight ops are discarded; no valid_out pulse for them after reset deasserts.
//  Pipeline:
//   - S1 registers on edge N when valid_in=1.
//   - S2 outputs on edge N+1; valid_out high in cycle after edge N+1.
//   - No stall/backpressure; consumer must accept every valid_out pulse.
//  When valid_in=0: the stage's valid bit clears. result/ovf hold the last valid value (no update).
//  S1 (unpack/align):
//   - s=op[31], e=op[30:23], m={e!=0, op[22:0]}.
//   - Denormals (e=0) are treated as zero.
//   - k=e-127:
//     - k<0: aligned mantissa shifted fully into round bits.
//     - 0<=k<=23: right shift by 23-k.
//     - 23<k<=30: left shift by k-23.
//   - Record guard bit + sticky (OR of all lower discarded bits).
//   - Overflow candidate when k>=31 or e=255.
//  S2 (round/sign/saturate):
//   - Increment if guard & (sticky | lsb).
//   - Rounding cannot carry past 2^31 (k<=30 exact above k=23).
//   - Negate if s.
//   - Special case: k=31, m==1.0, s=1 -> 32'h80000000, ovf=0.
//   - Other overflow: ovf=1; result per SAT_ENABLE.
//   - +0/-0/underflow -> 0, never 32'h80000000 from -0.
//  Simultaneous: valid_in together with reset -> reset wins; op dropped.
// TESTING
//  1. Round-to-nearest-even:
//     - 3FC00000 (1.5) -> 2; 40200000 (2.5) -> 2.
//     - BFC00000 (-1.5) -> FFFFFFFE; 3F000000 (0.5) -> 0; 3F400000 (0.75) -> 1.
//  2. Range edges:
//     - 4EFFFFFF -> 7FFFFF80 ovf=0; 4F000000 (2^31) -> 7FFFFFFF ovf=1.
//     - CF000000 -> 80000000 ovf=0; CF000001 -> 80000000 ovf=1.
//  3. Specials:
//     - 7F800000 -> 7FFFFFFF ovf=1; FF800000 -> 80000000 ovf=1.
//     - 7FC00000 -> 7FFFFFFF ovf=1 (SAT_ENABLE=1).
//     - 00000001 -> 0; 80000000 -> 0.
//  4. Throughput: 3 back-to-back valid ops (1.0, -2.0, 3.5), then 1 idle, then 1 op (7.0):
//     - valid_out pattern 1,1,1,0,1 starting 2 cycles after first op.
//     - results 1, FFFFFFFE, 4, -, 7.
//  5. Reset mid-flight:
//     - Assert reset 1 cycle after accepting 40400000.
//     - valid_out stays 0 for the next 3 cycles; result=0.
//  6. Random: 10000 $urandom operands vs C reference (lrintf + saturation), zero mismatches.
//     - Round-trip with itof on ints |x|<2^24 must be exact.

Source files
------------

// File: rtl/ftoi_if.sv
// Operand/result bundle between the ftoi converter and its producer/consumer.
// There is no backpressure: the consumer must take every valid_out pulse.
interface ftoi_if;
   logic [31:0] op;
   logic        valid_in;
   logic [31:0] result;
   logic        valid_out;
   logic        ovf;

   modport master (
      output op,
      output valid_in,
      input  result,
      input  valid_out,
      input  ovf
   );

   modport slave (
      input  op,
      input  valid_in,
      output result,
      output valid_out,
      output ovf
   );
endinterface

// File: rtl/ftoi_pipe.sv
// Two-stage binary32 -> int32 converter, round to nearest, ties to even.
// Stage 1 unpacks and aligns the operand; stage 2 rounds, applies the sign and saturates.
module ftoi_pipe #(
   parameter bit SAT_ENABLE = 1'b1
) (
   input logic   clk,
   input logic   reset,
   ftoi_if.slave bus
);

   // ---------------- stage 1: unpack / align ----------------
   logic              sgn_c;
   logic [7:0]        exp_c;
   logic [22:0]       frac_c;
   logic [23:0]       man_c;
   logic signed [9:0] k_c;
   logic signed [9:0] rsh_w;
   logic signed [9:0] lsh_w;
   logic [4:0]        rsh_c;
   logic [2:0]        lsh_c;
   logic [47:0]       ext_c;

   logic [30:0]       mag_c;
   logic              guard_c;
   logic              sticky_c;
   logic              ovf_c;
   logic              min_c;
   logic              nan_c;

   assign sgn_c  = bus.op[31];
   assign exp_c  = bus.op[30:23];
   assign frac_c = bus.op[22:0];
   assign man_c  = {(exp_c != 8'd0), frac_c};
   assign k_c    = $signed({2'b00, exp_c}) - 10'sd127;
   assign rsh_w  = 10'sd23 - k_c;
   assign lsh_w  = k_c - 10'sd23;
   assign rsh_c  = rsh_w[4:0];
   assign lsh_c  = lsh_w[2:0];
   assign ext_c  = {man_c, 24'd0} >> rsh_c;

   always_comb begin
      mag_c    = '0;
      guard_c  = 1'b0;
      sticky_c = 1'b0;
      ovf_c    = 1'b0;
      min_c    = 1'b0;
      nan_c    = 1'b0;
      if (exp_c == 8'hFF) begin
         ovf_c = 1'b1;
         nan_c = (frac_c != 23'd0);
      end else if (exp_c == 8'd0) begin
         // denormals and signed zeros flush to an all-zero magnitude
         mag_c = '0;
      end else if (k_c >= 10'sd31) begin
         ovf_c = 1'b1;
         min_c = sgn_c && (k_c == 10'sd31) && (frac_c == 23'd0);
      end else if (k_c >= 10'sd24) begin
         mag_c = {7'd0, man_c} << lsh_c;
      end else if (k_c >= -10'sd1) begin
         // k=-1 shifts by 24, leaving the hidden bit as the guard
         mag_c    = {7'd0, ext_c[47:24]};
         guard_c  = ext_c[23];
         sticky_c = |ext_c[22:0];
      end else begin
         sticky_c = 1'b1;
      end
   end

   logic        s1_valid;
   logic        s1_sgn;
   logic [30:0] s1_mag;
   logic        s1_guard;
   logic        s1_sticky;
   logic        s1_ovf;
   logic        s1_min;
   logic        s1_nan;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_sgn    <= 1'b0;
         s1_mag    <= '0;
         s1_guard  <= 1'b0;
         s1_sticky <= 1'b0;
         s1_ovf    <= 1'b0;
         s1_min    <= 1'b0;
         s1_nan    <= 1'b0;
      end else begin
         s1_valid <= bus.valid_in;
         if (bus.valid_in) begin
            s1_sgn    <= sgn_c;
            s1_mag    <= mag_c;
            s1_guard  <= guard_c;
            s1_sticky <= sticky_c;
            s1_ovf    <= ovf_c;
            s1_min    <= min_c;
            s1_nan    <= nan_c;
         end
      end
   end

   // ---------------- stage 2: round / sign / saturate ----------------
   logic        inc_c;
   logic [31:0] rnd_c;
   logic [31:0] signed_c;
   logic [31:0] res_c;
   logic        res_ovf_c;

   // largest finite magnitude is 0x7FFFFF80, so the increment never reaches bit 31
   assign inc_c    = s1_guard & (s1_sticky | s1_mag[0]);
   assign rnd_c    = {1'b0, s1_mag} + {31'd0, inc_c};
   assign signed_c = s1_sgn ? (32'd0 - rnd_c) : rnd_c;

   always_comb begin
      res_c     = signed_c;
      res_ovf_c = 1'b0;
      if (s1_min) begin
         res_c = 32'h8000_0000;
      end else if (s1_ovf) begin
         res_ovf_c = 1'b1;
         if (!SAT_ENABLE)
            res_c = 32'h8000_0000;
         else if (s1_nan || !s1_sgn)
            res_c = 32'h7FFF_FFFF;
         else
            res_c = 32'h8000_0000;
      end
   end

   logic [31:0] result_q;
   logic        ovf_q;
   logic        valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= s1_valid;
         if (s1_valid) begin
            result_q <= res_c;
            ovf_q    <= res_ovf_c;
         end
      end
   end

   assign bus.result    = result_q;
   assign bus.ovf       = ovf_q;
   assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: expected {ovf,result} queued at drive time, popped on valid_out.
module tb_ftoi_pipe;

   logic clk = 1'b0;
   logic reset;

   ftoi_if bus ();

   ftoi_pipe #(.SAT_ENABLE(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [32:0] sb_q[$];
   logic [31:0] vo_hist = '0;
   logic [31:0] last_res = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference: exact double arithmetic on the widened operand
   function automatic logic [32:0] model(input logic [31:0] f);
      logic [7:0]  e;
      logic [10:0] eb;
      logic [63:0] db;
      real         x, r, d;
      e = f[30:23];
      if (e == 8'hFF)
         return (f[22:0] != 23'd0 || !f[31]) ? {1'b1, 32'h7FFF_FFFF} : {1'b1, 32'h8000_0000};
      if (e == 8'd0)
         return 33'd0;
      eb = {3'b000, e} + 11'd896;
      db = {f[31], eb, f[22:0], 29'd0};
      x  = $bitstoreal(db);
      r  = $floor(x);
      d  = x - r;
      if (d > 0.5 || (d == 0.5 && (r / 2.0 != $floor(r / 2.0))))
         r = r + 1.0;
      if (r >= 2147483648.0)
         return {1'b1, 32'h7FFF_FFFF};
      if (r < -2147483648.0)
         return {1'b1, 32'h8000_0000};
      return {1'b0, 32'($rtoi(r))};
   endfunction

   function automatic logic [31:0] i2f(input int v);
      logic [31:0] m;
      logic [31:0] sh;
      int          p;
      if (v == 0)
         return 32'd0;
      m = (v < 0) ? 32'(-v) : 32'(v);
      p = 31;
      while (!m[p])
         p--;
      sh = m << (23 - p);
      return {(v < 0), 8'(127 + p), sh[22:0]};
   endfunction

   task automatic sample();
      logic [32:0] ent;
      vo_hist = {vo_hist[30:0], bus.valid_out};
      if (bus.valid_out === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_valid", {31'd0, bus.valid_out}, 32'd0);
         end else begin
            ent = sb_q.pop_front();
            check("result", bus.result, ent[31:0]);
            check("ovf", {31'd0, bus.ovf}, {31'd0, ent[32]});
            last_res = ent[31:0];
         end
      end
   endtask

   task automatic tick(input logic v, input logic [31:0] x, input logic [32:0] exp);
      @(negedge clk);
      sample();
      bus.valid_in = v;
      bus.op       = x;
      if (v)
         sb_q.push_back(exp);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb_q.size() != 0; i++)
         tick(1'b0, 32'd0, 33'd0);
      tick(1'b0, 32'd0, 33'd0);
      tick(1'b0, 32'd0, 33'd0);
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   typedef struct {
      logic [31:0] op;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   vec_t dir[$] = '{
      '{32'h3FC0_0000, 32'h0000_0002, 1'b0},
      '{32'h4020_0000, 32'h0000_0002, 1'b0},
      '{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0},
      '{32'h3F00_0000, 32'h0000_0000, 1'b0},
      '{32'hBF00_0000, 32'h0000_0000, 1'b0},
      '{32'h3F40_0000, 32'h0000_0001, 1'b0},
      '{32'h3F00_0001, 32'h0000_0001, 1'b0},
      '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0},
      '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1},
      '{32'hCF00_0000, 32'h8000_0000, 1'b0},
      '{32'hCF00_0001, 32'h8000_0000, 1'b1},
      '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1},
      '{32'hFF80_0000, 32'h8000_0000, 1'b1},
      '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1},
      '{32'h0000_0001, 32'h0000_0000, 1'b0},
      '{32'h8000_0000, 32'h0000_0000, 1'b0}
   };

   initial begin
      logic [31:0] x;
      int          iv;

      reset        = 1'b1;
      bus.valid_in = 1'b0;
      bus.op       = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_result", bus.result, 32'd0);
      check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
      check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
      reset = 1'b0;

      foreach (dir[i])
         tick(1'b1, dir[i].op, {dir[i].ovf, dir[i].res});
      drain();

      // throughput: three back-to-back ops, one bubble, one more op
      tick(1'b1, 32'h3F80_0000, {1'b0, 32'h0000_0001});
      tick(1'b1, 32'hC000_0000, {1'b0, 32'hFFFF_FFFE});
      tick(1'b1, 32'h4060_0000, {1'b0, 32'h0000_0004});
      tick(1'b0, 32'h0000_0000, 33'd0);
      tick(1'b1, 32'h40E0_0000, {1'b0, 32'h0000_0007});
      tick(1'b0, 32'd0, 33'd0);
      tick(1'b0, 32'd0, 33'd0);
      check("tput_pattern", {27'd0, vo_hist[4:0]}, 32'b11101);
      drain();
      check("hold_result", bus.result, last_res);

      // reset while an op is in flight, with an op offered during reset
      @(negedge clk);
      sample();
      bus.valid_in = 1'b1;
      bus.op       = 32'h4040_0000;
      @(negedge clk);
      sample();
      reset        = 1'b1;
      bus.valid_in = 1'b1;
      bus.op       = 32'h3F80_0000;
      @(negedge clk);
      reset        = 1'b0;
      bus.valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rstfl_valid", {31'd0, bus.valid_out}, 32'd0);
         check("rstfl_result", bus.result, 32'd0);
         @(negedge clk);
      end
      check("rstfl_valid_late", {31'd0, bus.valid_out}, 32'd0);

      // random operands, half with exponents near the integer range
      for (int i = 0; i < 10000; i++) begin
         x = $urandom;
         if (i % 2 == 1)
            x[30:23] = 8'($urandom_range(100, 160));
         if ($urandom_range(0, 9) < 8)
            tick(1'b1, x, model(x));
         else
            tick(1'b0, x, 33'd0);
      end
      drain();

      // round trip of exact integers through their binary32 encoding
      for (int i = 0; i < 300; i++) begin
         iv = int'($urandom_range(0, 32'h00FF_FFFF));
         if ($urandom_range(0, 1) == 1)
            iv = -iv;
         tick(1'b1, i2f(iv), {1'b0, 32'(iv)});
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
